// File: rtl/umi_pkg.sv
// Shared UMI opcode constants and request classification helper.
package umi_pkg;

  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
  localparam logic [4:0] UMI_REQ_ATOMIC = 5'h09;

  // True for opcodes that will produce a response from the RAM.
  function automatic logic umi_expects_resp(input logic [4:0] opcode);
    return (opcode == UMI_REQ_READ) || (opcode == UMI_REQ_WRITE) ||
           (opcode == UMI_REQ_ATOMIC);
  endfunction

endpackage

// File: rtl/umi_tag_fifo.sv
// Small synchronous FIFO holding the host's original ID bits for each
// response-expecting request, in issue order; head is readable combinationally.
module umi_tag_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  always_comb begin
    full    = (count_q == CNTW'(DEPTH));
    empty   = (count_q == '0);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    do_push = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
    head    = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/umi_req_tracker.sv
// Per-port request shim: stamps the port ID into request srcaddr, bounds
// outstanding responses, and restores the host ID bits on returning responses.
module umi_req_tracker
  import umi_pkg::*;
#(
  parameter int CW     = 32,
  parameter int AW     = 64,
  parameter int DW     = 256,
  parameter int N      = 1,
  parameter int IDOFF  = 40,
  parameter int PORTID = 0,
  parameter int MAXOUT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         host_req_valid,
  input  logic [CW-1:0]                host_req_cmd,
  input  logic [AW-1:0]                host_req_dstaddr,
  input  logic [AW-1:0]                host_req_srcaddr,
  input  logic [DW-1:0]                host_req_data,
  output logic                         host_req_ready,
  output logic                         dev_req_valid,
  output logic [CW-1:0]                dev_req_cmd,
  output logic [AW-1:0]                dev_req_dstaddr,
  output logic [AW-1:0]                dev_req_srcaddr,
  output logic [DW-1:0]                dev_req_data,
  input  logic                         dev_req_ready,
  input  logic                         dev_resp_valid,
  input  logic [CW-1:0]                dev_resp_cmd,
  input  logic [AW-1:0]                dev_resp_dstaddr,
  input  logic [AW-1:0]                dev_resp_srcaddr,
  input  logic [DW-1:0]                dev_resp_data,
  output logic                         dev_resp_ready,
  output logic                         host_resp_valid,
  output logic [CW-1:0]                host_resp_cmd,
  output logic [AW-1:0]                host_resp_dstaddr,
  output logic [AW-1:0]                host_resp_srcaddr,
  output logic [DW-1:0]                host_resp_data,
  input  logic                         host_resp_ready,
  output logic [$clog2(MAXOUT+1)-1:0]  outstanding,
  output logic                         err_unexpected
);

  localparam int OW = $clog2(MAXOUT + 1);
  localparam int RW = CW + AW + AW + DW;
  localparam logic [N-1:0] PORT_ONEHOT = N'(1) << PORTID;

  logic          head_valid_q, head_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [RW-1:0] head_data_q, head_data_d;
  logic [RW-1:0] skid_data_q, skid_data_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic          err_q, err_d;

  logic          req_expects, host_req_fire, dev_req_fire, resp_fire, resp_tracked;
  logic          tag_push, tag_full, tag_empty;
  logic [N-1:0]  tag_head;
  logic [AW-1:0] stamped_srcaddr, restored_dstaddr;
  logic [RW-1:0] new_req;

  always_comb begin
    req_expects    = umi_expects_resp(host_req_cmd[4:0]);
    // The tag FIFO occupancy tracks outstanding exactly, so its full/empty
    // flags double as the outstanding==MAXOUT / outstanding==0 tests.
    host_req_ready = !reset && !(head_valid_q && skid_valid_q) &&
                     !(req_expects && tag_full);
    host_req_fire  = host_req_valid && host_req_ready;
    tag_push       = host_req_fire && req_expects;
    dev_req_fire   = head_valid_q && dev_req_ready;
    resp_fire      = dev_resp_valid && host_resp_ready;
    resp_tracked   = resp_fire && !tag_empty;

    stamped_srcaddr               = host_req_srcaddr;
    stamped_srcaddr[IDOFF +: N]   = PORT_ONEHOT;
    new_req = {host_req_cmd, host_req_dstaddr, stamped_srcaddr, host_req_data};

    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (dev_req_fire) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_data_d  = skid_data_q;
        skid_valid_d = host_req_fire;
        skid_data_d  = new_req;
      end else begin
        head_valid_d = host_req_fire;
        head_data_d  = new_req;
      end
    end else if (host_req_fire) begin
      if (!head_valid_q) begin
        head_valid_d = 1'b1;
        head_data_d  = new_req;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = new_req;
      end
    end

    outstanding_d = outstanding_q + OW'(tag_push) - OW'(resp_tracked);
    err_d         = err_q || (resp_fire && tag_empty);

    restored_dstaddr = dev_resp_dstaddr;
    if (!tag_empty) begin
      restored_dstaddr[IDOFF +: N] = tag_head;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      head_valid_q  <= head_valid_d;
      skid_valid_q  <= skid_valid_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    head_data_q <= head_data_d;
    skid_data_q <= skid_data_d;
  end

  umi_tag_fifo #(
    .W     (N),
    .DEPTH (MAXOUT)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_push),
    .push_data (host_req_srcaddr[IDOFF +: N]),
    .pop       (resp_tracked),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  assign dev_req_valid = head_valid_q;
  assign {dev_req_cmd, dev_req_dstaddr, dev_req_srcaddr, dev_req_data} = head_data_q;

  assign host_resp_valid   = dev_resp_valid;
  assign dev_resp_ready    = host_resp_ready;
  assign host_resp_cmd     = dev_resp_cmd;
  assign host_resp_dstaddr = restored_dstaddr;
  assign host_resp_srcaddr = dev_resp_srcaddr;
  assign host_resp_data    = dev_resp_data;

  assign outstanding    = outstanding_q;
  assign err_unexpected = err_q;

endmodule
